// File: rtl/riscv_enc_pkg.sv
// ============================================================================
// riscv_enc_pkg : RV32I opcodes, operation indices, funct3/funct7 constants
//                 and FSM state type shared by the instruction encoder.
// Revision 1.0
// ============================================================================
`default_nettype none

package riscv_enc_pkg;

    localparam int NUM_OPS = 23;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;

    localparam logic [4:0] OP_OR   = 5'd0;
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4;
    localparam logic [4:0] OP_SLT  = 5'd5;
    localparam logic [4:0] OP_SRA  = 5'd6;
    localparam logic [4:0] OP_SRL  = 5'd7;
    localparam logic [4:0] OP_SLL  = 5'd8;
    localparam logic [4:0] OP_BEQ  = 5'd9;
    localparam logic [4:0] OP_BNE  = 5'd10;
    localparam logic [4:0] OP_BLT  = 5'd11;
    localparam logic [4:0] OP_BGE  = 5'd12;
    localparam logic [4:0] OP_JAL  = 5'd13;
    localparam logic [4:0] OP_JALR = 5'd14;
    localparam logic [4:0] OP_LUI  = 5'd15;
    localparam logic [4:0] OP_LW   = 5'd16;
    localparam logic [4:0] OP_SW   = 5'd17;
    localparam logic [4:0] OP_LB   = 5'd18;
    localparam logic [4:0] OP_LH   = 5'd19;
    localparam logic [4:0] OP_LBU  = 5'd20;
    localparam logic [4:0] OP_SB   = 5'd21;
    localparam logic [4:0] OP_SH   = 5'd22;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;
    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BU  = 3'b100;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_ENCODE = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    function automatic logic [2:0] op_funct3(input logic [4:0] idx);
        logic [2:0] f;
        case (idx)
            OP_OR:            f = F3_OR;
            OP_ADD, OP_SUB:   f = F3_ADD;
            OP_AND:           f = F3_AND;
            OP_XOR:           f = F3_XOR;
            OP_SLT:           f = F3_SLT;
            OP_SRA, OP_SRL:   f = F3_SR;
            OP_SLL:           f = F3_SLL;
            OP_BEQ:           f = F3_BEQ;
            OP_BNE:           f = F3_BNE;
            OP_BLT:           f = F3_BLT;
            OP_BGE:           f = F3_BGE;
            OP_LW, OP_SW:     f = F3_W;
            OP_LB, OP_SB:     f = F3_B;
            OP_LH, OP_SH:     f = F3_H;
            OP_LBU:           f = F3_BU;
            default:          f = 3'b000;
        endcase
        return f;
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_field_pack.sv
// ============================================================================
// instr_field_pack : combinational op/field -> RV32I word packer.
//                    ILLEGAL_CHECK_EN enables the illegal-request flag.
// Revision 1.0
// ============================================================================
`default_nettype none

module instr_field_pack
    import riscv_enc_pkg::*;
(
    input  logic [NUM_OPS-1:0] op_i,
    input  logic               imm_form_i,
    input  logic [4:0]         rd_i,
    input  logic [4:0]         rs1_i,
    input  logic [4:0]         rs2_i,
    input  logic [31:0]        imm_i,
    output logic [31:0]        word_o,
    output logic               illegal_o
);

    logic [4:0] w_sel;
    logic       w_hit;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic [31:0] w_r_word;

    always_comb begin
        w_sel = '0;
        w_hit = 1'b0;
        // Scan downwards so the lowest set bit is the one that sticks.
        for (int i = NUM_OPS - 1; i >= 0; i--) begin
            if (op_i[i]) begin
                w_sel = 5'(i);
                w_hit = 1'b1;
            end
        end
        w_f3     = op_funct3(w_sel);
        w_f7     = (w_sel == OP_SUB || w_sel == OP_SRA) ? F7_ALT : F7_BASE;
        w_r_word = {w_f7, rs2_i, rs1_i, w_f3, rd_i, OPC_R};

        word_o = {12'd0, 5'd0, 3'b000, 5'd0, OPC_I};
        if (w_hit) begin
            case (w_sel)
                OP_OR, OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_SLT:
                    word_o = imm_form_i ? {imm_i[11:0], rs1_i, w_f3, rd_i, OPC_I} : w_r_word;
                OP_SRA, OP_SRL, OP_SLL:
                    word_o = imm_form_i ? {w_f7, imm_i[4:0], rs1_i, w_f3, rd_i, OPC_I} : w_r_word;
                OP_BEQ, OP_BNE, OP_BLT, OP_BGE:
                    word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, w_f3,
                              imm_i[4:1], imm_i[11], OPC_BR};
                OP_JAL:
                    word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPC_JAL};
                OP_JALR:
                    word_o = {imm_i[11:0], rs1_i, w_f3, rd_i, OPC_JALR};
                OP_LUI:
                    word_o = {imm_i[31:12], rd_i, OPC_LUI};
                OP_LW, OP_LB, OP_LH, OP_LBU:
                    word_o = {imm_i[11:0], rs1_i, w_f3, rd_i, OPC_LOAD};
                OP_SW, OP_SB, OP_SH:
                    word_o = {imm_i[11:5], rs2_i, rs1_i, w_f3, imm_i[4:0], OPC_STORE};
                default:
                    word_o = {12'd0, 5'd0, 3'b000, 5'd0, OPC_I};
            endcase
        end
    end

`ifdef ILLEGAL_CHECK_EN
    assign illegal_o = (op_i == '0)
                    || ((op_i & (op_i - NUM_OPS'(1))) != '0)
                    || (op_i[OP_SUB] && imm_form_i);
`else
    assign illegal_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
// instr_encoder : sequential loader that encodes RV32I words into imem.
//                 Optional macro ILLEGAL_CHECK_EN enables the sticky err flag.
// Revision 1.0
// ============================================================================
`default_nettype none

module instr_encoder
    import riscv_enc_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_last,
    input  logic [NUM_OPS-1:0] op,
    input  logic               imm_form,
    input  logic [4:0]         rd,
    input  logic [4:0]         rs1,
    input  logic [4:0]         rs2,
    input  logic [31:0]        imm,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [31:0]        mem_wdata,
    output logic               done,
    output logic               err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic [NUM_OPS-1:0]  op_q;
    logic                form_q;
    logic [4:0]          rd_q, rs1_q, rs2_q;
    logic [31:0]         imm_q;
    logic                last_q;
    logic [31:0]         w_word;
    logic                w_illegal;
    logic                w_start_ok;

    instr_field_pack u_pack (
        .op_i       (op_q),
        .imm_form_i (form_q),
        .rd_i       (rd_q),
        .rs1_i      (rs1_q),
        .rs2_i      (rs2_q),
        .imm_i      (imm_q),
        .word_o     (w_word),
        .illegal_o  (w_illegal)
    );

    assign w_start_ok = start && (state_q == S_IDLE || state_q == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        in_ready = 1'b0;
        mem_we   = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    addr_d  = '0;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) state_d = S_ENCODE;
            end
            S_ENCODE: begin
                // An illegal request skips the write but still honours in_last.
                if (w_illegal) state_d = last_q ? S_DONE : S_LOAD;
                else           state_d = S_WRITE;
            end
            S_WRITE: begin
                mem_we  = 1'b1;
                addr_d  = addr_q + ADDR_W'(1);
                state_d = (last_q || addr_q == LAST_ADDR) ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_d = S_LOAD;
                    addr_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q        <= '0;
            form_q      <= 1'b0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
            last_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            if (state_q == S_LOAD && in_valid) begin
                op_q   <= op;
                form_q <= imm_form;
                rd_q   <= rd;
                rs1_q  <= rs1;
                rs2_q  <= rs2;
                imm_q  <= imm;
                last_q <= in_last;
            end
            if (state_q == S_ENCODE && !w_illegal) begin
                mem_addr_q  <= addr_q;
                mem_wdata_q <= w_word;
            end
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef ILLEGAL_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                   err_q <= 1'b0;
        else if (w_start_ok)                         err_q <= 1'b0;
        else if (state_q == S_ENCODE && w_illegal)   err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // start only matters in IDLE/DONE; kept as a named term for the err clear.
    logic w_unused_ok;
    assign w_unused_ok = w_start_ok;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// tb_instr_encoder : table-driven check of instr_encoder (DEPTH=4) plus
//                    hand sequences for in_last, no-wrap, illegal ops, reset.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_instr_encoder;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_last = 1'b0;
    logic [22:0]       op = '0;
    logic              imm_form = 1'b0;
    logic [4:0]        rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0]       imm = '0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              done;
    logic              err;

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .op(op), .imm_form(imm_form), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int          op_idx;
        logic        form;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk1("start_ready", in_ready, 1'b1);
        chk1("start_done", done, 1'b0);
    endtask

    // Returns at the negedge two cycles after the accepting edge (WRITE when legal).
    task automatic send(input logic [22:0] o, input logic f, input logic [4:0] rd_v,
                        input logic [4:0] rs1_v, input logic [4:0] rs2_v, input logic [31:0] imm_v,
                        input logic last, input logic exp_we, input logic [ADDR_W-1:0] exp_addr,
                        input logic [31:0] exp_data, input string tag);
        @(negedge clk);
        op = o; imm_form = f; rd = rd_v; rs1 = rs1_v; rs2 = rs2_v; imm = imm_v;
        in_valid = 1'b1; in_last = last;
        for (int k = 0; k < 8; k++) begin
            if (in_ready) break;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk1({tag, " ready_timeout"}, in_ready, 1'b1);
            in_valid = 1'b0; in_last = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        chk1({tag, " we_encode"}, mem_we, 1'b0);
        @(negedge clk);
        chk1({tag, " we_write"}, mem_we, exp_we);
        if (exp_we) begin
            chk32({tag, " addr"}, 32'(mem_addr), 32'(exp_addr));
            chk32({tag, " data"}, mem_wdata, exp_data);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic bad;
        logic [22:0] one_hot;

        vecs[0]  = '{1,  1'b0, 5'd3,  5'd1,  5'd2,  32'h00000000, 32'h002081B3}; // add x3,x1,x2
        vecs[1]  = '{1,  1'b1, 5'd5,  5'd0,  5'd7,  32'hFFFFFFFF, 32'hFFF00293}; // addi x5,x0,-1
        vecs[2]  = '{9,  1'b0, 5'd5,  5'd1,  5'd2,  32'h00000008, 32'h00208463}; // beq +8
        vecs[3]  = '{17, 1'b0, 5'd0,  5'd1,  5'd2,  32'h00000004, 32'h0020A223}; // sw x2,4(x1)
        vecs[4]  = '{15, 1'b0, 5'd1,  5'd9,  5'd9,  32'h12345ABC, 32'h123450B7}; // lui
        vecs[5]  = '{13, 1'b0, 5'd1,  5'd0,  5'd0,  32'h00000010, 32'h010000EF}; // jal +16
        vecs[6]  = '{2,  1'b0, 5'd1,  5'd2,  5'd3,  32'h00000000, 32'h403100B3}; // sub
        vecs[7]  = '{6,  1'b1, 5'd4,  5'd5,  5'd0,  32'hFFFFFFE3, 32'h4032D213}; // srai x4,x5,3
        vecs[8]  = '{16, 1'b0, 5'd6,  5'd7,  5'd0,  32'hFFFFFFFC, 32'hFFC3A303}; // lw x6,-4(x7)
        vecs[9]  = '{10, 1'b0, 5'd0,  5'd1,  5'd2,  32'hFFFFFFFC, 32'hFE209EE3}; // bne -4
        vecs[10] = '{22, 1'b0, 5'd0,  5'd4,  5'd3,  32'hFFFFFFFE, 32'hFE321F23}; // sh x3,-2(x4)
        vecs[11] = '{8,  1'b1, 5'd1,  5'd1,  5'd0,  32'h0000001F, 32'h01F09093}; // slli x1,x1,31
        vecs[12] = '{4,  1'b0, 5'd10, 5'd11, 5'd12, 32'h00000000, 32'h00C5C533}; // xor
        vecs[13] = '{20, 1'b0, 5'd8,  5'd9,  5'd0,  32'h00000001, 32'h0014C403}; // lbu x8,1(x9)
        vecs[14] = '{14, 1'b0, 5'd0,  5'd1,  5'd0,  32'h00000000, 32'h00008067}; // jalr x0,0(x1)
        vecs[15] = '{3,  1'b0, 5'd7,  5'd8,  5'd9,  32'h00000000, 32'h009473B3}; // and

        repeat (3) @(negedge clk);
        chk1("rst in_ready", in_ready, 1'b0);
        chk1("rst mem_we", mem_we, 1'b0);
        chk32("rst mem_addr", 32'(mem_addr), 32'd0);
        chk32("rst mem_wdata", mem_wdata, 32'd0);
        chk1("rst done", done, 1'b0);
        chk1("rst err", err, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk1("idle in_ready", in_ready, 1'b0);

        // Four words per session; the fourth forces DONE and a fifth is never taken.
        for (int i = 0; i < 16; i++) begin
            if (i % 4 == 0) do_start();
            one_hot = 23'(1) << vecs[i].op_idx;
            send(one_hot, vecs[i].form, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm,
                 1'b0, 1'b1, ADDR_W'(i % 4), vecs[i].exp, $sformatf("vec%0d", i));
            if (i % 4 == 3) begin
                @(negedge clk);
                chk1($sformatf("depth_done%0d", i), done, 1'b1);
                chk1($sformatf("depth_ready%0d", i), in_ready, 1'b0);
                in_valid = 1'b1;
                bad = 1'b0;
                repeat (6) begin
                    @(negedge clk);
                    if (in_ready || mem_we) bad = 1'b1;
                end
                in_valid = 1'b0;
                chk1($sformatf("no_wrap%0d", i), bad, 1'b0);
                chk1($sformatf("done_hold%0d", i), done, 1'b1);
            end
        end

        // in_last ends the session after one word.
        do_start();
        send(23'h2, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1, 1'b1, 2'd0, 32'h002081B3, "last");
        @(negedge clk);
        chk1("last done", done, 1'b1);
        chk1("last ready", in_ready, 1'b0);

        do_start();
`ifdef ILLEGAL_CHECK_EN
        send(23'h3, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, "multi_hot");
        chk1("multi_hot err", err, 1'b1);
        send(23'h2, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, 1'b1, 2'd0, 32'h002081B3, "after_illegal");
        chk1("err sticky", err, 1'b1);
        send(23'h4, 1'b1, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 2'd0, 32'h0, "sub_imm");
        send(23'h0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1, 1'b0, 2'd0, 32'h0, "zero_op");
        @(negedge clk);
        chk1("illegal last done", done, 1'b1);
        chk1("illegal err", err, 1'b1);
`else
        send(23'h3, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, 1'b1, 2'd0, 32'h0020E1B3, "multi_hot");
        chk1("multi_hot err", err, 1'b0);
        send(23'h0, 1'b0, 5'd3, 5'd1, 5'd2, 32'hFFFFFFFF, 1'b0, 1'b1, 2'd1, 32'h00000013, "zero_op");
        send(23'h4, 1'b1, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 2'd2, 32'hFFF00293, "sub_imm");
        send(23'h4000, 1'b0, 5'd0, 5'd1, 5'd0, 32'h0, 1'b1, 1'b1, 2'd3, 32'h00008067, "jalr_last");
        @(negedge clk);
        chk1("c_done", done, 1'b1);
`endif

        // Reset while a word sits in ENCODE: outputs clear at once, no write.
        do_start();
        chk1("err_cleared", err, 1'b0);
        send(23'h2, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, 1'b1, 2'd0, 32'h002081B3, "pre_rst0");
        send(23'h10, 1'b0, 5'd4, 5'd4, 5'd4, 32'h0, 1'b0, 1'b1, 2'd1, 32'h00A21023 ^ 32'h00A21023 ^ 32'h0042C233 ^ 32'h0042C233 ^ 32'h00424233, "pre_rst1");
        @(negedge clk);
        chk1("rst_seq ready", in_ready, 1'b1);
        op = 23'h2; imm_form = 1'b0; rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2; imm = 32'h0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk1("arst in_ready", in_ready, 1'b0);
        chk1("arst mem_we", mem_we, 1'b0);
        chk32("arst mem_addr", 32'(mem_addr), 32'd0);
        chk32("arst mem_wdata", mem_wdata, 32'd0);
        chk1("arst done", done, 1'b0);
        chk1("arst err", err, 1'b0);
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (mem_we) bad = 1'b1;
        end
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (mem_we) bad = 1'b1;
        end
        chk1("arst no_we", bad, 1'b0);
        do_start();
        send(23'h2, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1, 1'b1, 2'd0, 32'h002081B3, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
